// File: rtl/mmio_bus_decoder_pkg.sv
// mmio_bus_decoder_pkg: FSM state encoding, fault defaults, SoC slave window table and helpers
package mmio_bus_decoder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
  localparam int SOC_NUM_SLAVES = 8;
  localparam logic [31:0] SOC_FAULT_RDATA = 32'h0000_0000;
  // Slave 3 sits inside slave 0's window on purpose; the lower index owns the overlap.
  localparam logic [8*32-1:0] SOC_SLAVE_BASE = {
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_1000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000
  };
  localparam logic [8*32-1:0] SOC_SLAVE_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000
  };
  localparam logic [7:0] SOC_SLAVE_RO = 8'b0000_0010;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/mmio_bus_decoder_addr_match_encoder.sv
// mmio_bus_decoder_addr_match_encoder: base/mask window compare with lowest-index priority
//   addr_i  byte address to decode
//   hit_o   some window matched
//   sel_o   index of the lowest matching window
module mmio_bus_decoder_addr_match_encoder
  import mmio_bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = SOC_NUM_SLAVES,
  parameter int ADDR_W = 32,
  parameter int SEL_W = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = SOC_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = SOC_SLAVE_MASK
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  sel_o
);
  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
  end
endmodule

// File: rtl/mmio_bus_decoder.sv
// mmio_bus_decoder: single-master / N-slave MMIO decoder with read-only protection, timeout and fault response
//   clk_i, resetn_i                                   clock, asynchronous active-low reset
//   m_valid_i, m_addr_i, m_wstrb_i, m_wdata_i         master request (wstrb 0 = read)
//   m_ready_o, m_rdata_o, m_fault_o                   one-cycle master response
//   s_valid_o, s_addr_o, s_wstrb_o, s_wdata_o         one-hot slave request with shared latched payload
//   s_ready_i, s_rdata_i                              per-slave completion and packed read data
//   fault_cnt_o                                       saturating count of faulted responses
module mmio_bus_decoder
  import mmio_bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = SOC_NUM_SLAVES,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = SOC_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = SOC_SLAVE_MASK,
  parameter logic [NUM_SLAVES-1:0] SLAVE_RO = SOC_SLAVE_RO,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] FAULT_RDATA = SOC_FAULT_RDATA
) (
  input  logic                         clk_i,
  input  logic                         resetn_i,
  input  logic                         m_valid_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W/8-1:0]          m_wstrb_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  output logic                         m_ready_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_fault_o,
  output logic [NUM_SLAVES-1:0]        s_valid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES-1:0]        s_ready_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic [15:0]                  fault_cnt_o
);
  localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter starts at 0 on the first REQ cycle, so the last allowed cycle is TIMEOUT_CYCLES-1.
  localparam int TO_LAST = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, dec_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W/8-1:0] s_wstrb_q, s_wstrb_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  logic m_fault_q, m_fault_d, m_ready_q, dec_hit;
  logic [15:0] fault_cnt_q;
  mmio_bus_decoder_addr_match_encoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .ADDR_W(ADDR_W),
    .SEL_W(SEL_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_match (
    .addr_i(m_addr_i),
    .hit_o(dec_hit),
    .sel_o(dec_sel)
  );
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = '0;
    s_valid_d = '0;
    s_addr_d = s_addr_q;
    s_wstrb_d = s_wstrb_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_fault_d = m_fault_q;
    case (state_q)
      ST_IDLE: if (m_valid_i) begin
        s_addr_d = m_addr_i;
        s_wstrb_d = m_wstrb_i;
        s_wdata_d = m_wdata_i;
        sel_d = dec_sel;
        if (dec_hit && !(SLAVE_RO[dec_sel] && |m_wstrb_i)) begin
          state_d = ST_REQ;
          s_valid_d = NUM_SLAVES'(1) << dec_sel;
        end else begin
          state_d = ST_RESP;
          m_fault_d = 1'b1;
          m_rdata_d = FAULT_RDATA;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        s_valid_d = s_valid_q;
        // Ready is tested first so it wins over a timeout in the same cycle.
        if (s_ready_i[sel_q]) begin
          state_d = ST_RESP;
          s_valid_d = '0;
          m_fault_d = 1'b0;
          m_rdata_d = |s_wstrb_q ? '0 : s_rdata_i[sel_q*DATA_W +: DATA_W];
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TO_LAST)) begin
          state_d = ST_RESP;
          s_valid_d = '0;
          m_fault_d = 1'b1;
          m_rdata_d = FAULT_RDATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      s_valid_q <= '0;
      s_addr_q <= '0;
      s_wstrb_q <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_fault_q <= 1'b0;
      m_ready_q <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      s_valid_q <= s_valid_d;
      s_addr_q <= s_addr_d;
      s_wstrb_q <= s_wstrb_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_fault_q <= m_fault_d;
      m_ready_q <= state_d == ST_RESP;
      fault_cnt_q <= (state_q == ST_RESP && m_fault_q) ? sat_inc16(fault_cnt_q) : fault_cnt_q;
    end
  assign m_ready_o = m_ready_q;
  assign m_rdata_o = m_rdata_q;
  assign m_fault_o = m_fault_q;
  assign s_valid_o = s_valid_q;
  assign s_addr_o = s_addr_q;
  assign s_wstrb_o = s_wstrb_q;
  assign s_wdata_o = s_wdata_q;
  assign fault_cnt_o = fault_cnt_q;
endmodule

// File: tb/tb_mmio_bus_decoder.sv
// tb_mmio_bus_decoder: scoreboard bench for mmio_bus_decoder on the SoC slave table with a 4-cycle timeout
module tb_mmio_bus_decoder;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic m_valid = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0] m_wstrb = '0;
  logic [31:0] m_wdata = '0;
  logic m_ready_o, m_fault_o;
  logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
  logic [7:0] s_valid_o;
  logic [3:0] s_wstrb_o;
  logic [7:0] s_ready = '0;
  logic [255:0] s_rdata = '0;
  logic [15:0] fault_cnt_o;
  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];
  always #5 clk = ~clk;
  mmio_bus_decoder #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wstrb_i(m_wstrb), .m_wdata_i(m_wdata),
    .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o), .m_fault_o(m_fault_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wstrb_o(s_wstrb_o), .s_wdata_o(s_wdata_o),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata), .fault_cnt_o(fault_cnt_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (resetn && m_ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected m_ready: rdata=%h fault=%b with nothing pending", m_rdata_o, m_fault_o);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("m_rdata", m_rdata_o, e[32:1]);
        chk("m_fault", {31'd0, m_fault_o}, {31'd0, e[0]});
      end
    end
  // rs: slave raising s_ready on its rdy_at-th s_valid cycle (0 = never); ign: other slave pulsing ready on cycle 1.
  task automatic txn(input string nm, input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                     input int rs, input int rdy_at, input logic [31:0] rd, input int ign,
                     input int exp_sv, input int exp_svc, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_fault);
    int svc, lat;
    logic bad;
    svc = 0;
    lat = 0;
    bad = 1'b0;
    @(negedge clk);
    m_valid = 1'b1;
    m_addr = addr;
    m_wstrb = wstrb;
    m_wdata = wdata;
    s_rdata = '0;
    if (rs >= 0) s_rdata[rs*32 +: 32] = rd;
    if (ign >= 0) s_rdata[ign*32 +: 32] = 32'hBADB_AD00;
    sb.push_back({exp_rdata, exp_fault});
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      s_ready = '0;
      if (s_valid_o != 0) begin
        svc++;
        if (s_valid_o != (8'd1 << exp_sv) || s_addr_o != addr || s_wstrb_o != wstrb || s_wdata_o != wdata) bad = 1'b1;
        if (rs >= 0 && svc == rdy_at) s_ready[rs] = 1'b1;
        if (ign >= 0 && svc == 1) s_ready[ign] = 1'b1;
      end
      if (m_ready_o) begin
        lat = k + 1;
        m_valid = 1'b0;
      end
    end
    s_ready = '0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " s_valid cycles"}, svc, exp_svc);
    chk({nm, " slave side"}, {31'd0, bad}, 32'd0);
    @(negedge clk);
    chk({nm, " m_ready width"}, {31'd0, m_ready_o}, 32'd0);
  endtask
  initial begin
    #3 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset m_rdata", m_rdata_o, 32'd0);
    chk("reset ready/fault", {30'd0, m_ready_o, m_fault_o}, 32'd0);
    chk("reset s_valid", {24'd0, s_valid_o}, 32'd0);
    chk("reset s_addr", s_addr_o, 32'd0);
    chk("reset s_wdata/wstrb", s_wdata_o | {28'd0, s_wstrb_o}, 32'd0);
    chk("reset fault_cnt", {16'd0, fault_cnt_o}, 32'd0);
    resetn = 1'b1;
    txn("rd s2", 32'h1000_0004, 4'h0, 32'h0, 2, 2, 32'hDEAD_BEEF, -1, 2, 2, 4, 32'hDEAD_BEEF, 1'b0);
    txn("rd s4 fast", 32'h4000_0010, 4'h0, 32'h0, 4, 1, 32'h0BAD_F00D, -1, 4, 1, 3, 32'h0BAD_F00D, 1'b0);
    txn("wr ro s1", 32'h2000_0000, 4'hF, 32'h1111_2222, 1, 1, 32'h7777_7777, -1, 1, 0, 2, 32'h0, 1'b1);
    chk("fault_cnt after ro", {16'd0, fault_cnt_o}, 32'd1);
    txn("unmapped", 32'hF000_0000, 4'h0, 32'h0, -1, 0, 32'h0, -1, 0, 0, 2, 32'h0, 1'b1);
    chk("fault_cnt after unmapped", {16'd0, fault_cnt_o}, 32'd2);
    txn("timeout", 32'h5000_0000, 4'h0, 32'h0, 5, 0, 32'h5555_AAAA, -1, 5, 4, 6, 32'h0, 1'b1);
    chk("fault_cnt after timeout", {16'd0, fault_cnt_o}, 32'd3);
    txn("ready at timeout", 32'h5000_0000, 4'h0, 32'h0, 5, 4, 32'h5555_AAAA, -1, 5, 4, 6, 32'h5555_AAAA, 1'b0);
    chk("fault_cnt ready wins", {16'd0, fault_cnt_o}, 32'd3);
    txn("overlap", 32'h3000_1000, 4'h0, 32'h0, 0, 2, 32'h0000_0A0A, 3, 0, 2, 4, 32'h0000_0A0A, 1'b0);
    txn("wr s2", 32'h1000_0008, 4'h3, 32'h1234_5678, 2, 1, 32'hFFFF_FFFF, -1, 2, 1, 3, 32'h0, 1'b0);
    txn("rd ro s1", 32'h2000_0010, 4'h0, 32'h0, 1, 1, 32'hCAFE_F00D, -1, 1, 1, 3, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    m_valid = 1'b1;
    m_addr = 32'h6000_0000;
    m_wstrb = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_valid_o != 0) break;
    end
    chk("pre-reset s_valid", {24'd0, s_valid_o}, 32'h40);
    #2 resetn = 1'b0;
    #1;
    chk("mid-req reset s_valid", {24'd0, s_valid_o}, 32'd0);
    chk("mid-req reset fault_cnt", {16'd0, fault_cnt_o}, 32'd0);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    txn("rd s6 after reset", 32'h6000_0020, 4'h0, 32'h0, 6, 1, 32'h6666_0001, -1, 6, 1, 3, 32'h6666_0001, 1'b0);
    txn("unmapped after reset", 32'h8000_0000, 4'h0, 32'h0, -1, 0, 32'h0, -1, 0, 0, 2, 32'h0, 1'b1);
    chk("fault_cnt restarted", {16'd0, fault_cnt_o}, 32'd1);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
